// File: rtl/id_sort_buffer_pkg.sv
// sys_defs: shared IF/ID packet type, NOP constant and default sizing
package sys_defs;

    localparam int DEF_WAYS  = 3;
    localparam int DEF_DEPTH = 8;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        valid;
    } IF_ID_PACKET;

    localparam IF_ID_PACKET NOP_PACKET = '0;

endpackage

// File: rtl/id_sort_network.sv
// id_sort_network: stable ascending-PC rank sort that compacts out invalid lanes
module id_sort_network
    import sys_defs::*;
#(
    parameter int WAYS = DEF_WAYS
) (
    input  IF_ID_PACKET [WAYS-1:0]       in_packets,
    output IF_ID_PACKET [WAYS-1:0]       sorted,
    output logic [$clog2(WAYS+1)-1:0]    n_in
);

    localparam int CW = $clog2(WAYS + 1);
    localparam int RW = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [RW-1:0] rank;
    int            cnt;

    // Each valid lane lands at its rank: older-or-equal lanes with a lower PC (or same PC, lower lane) go first
    always_comb begin
        sorted = {WAYS{NOP_PACKET}};
        rank   = '0;
        cnt    = 0;
        for (int i = 0; i < WAYS; i++) begin
            rank = '0;
            for (int j = 0; j < WAYS; j++)
                if (in_packets[j].valid && (in_packets[j].pc < in_packets[i].pc ||
                    (in_packets[j].pc == in_packets[i].pc && j < i)))
                    rank = RW'(rank + 1);
            if (in_packets[i].valid) begin
                sorted[rank] = in_packets[i];
                cnt          = cnt + 1;
            end
        end
        n_in = CW'(cnt);
    end

endmodule

// File: rtl/id_sort_buffer.sv
// id_sort_buffer: sorts fetch lanes by PC and queues them in a circular buffer feeding decode in program order
module id_sort_buffer
    import sys_defs::*;
#(
    parameter int WAYS  = DEF_WAYS,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  IF_ID_PACKET [WAYS-1:0]         in_packets,
    output logic                           in_ready,
    input  logic [$clog2(WAYS+1)-1:0]      out_accept,
    output IF_ID_PACKET [WAYS-1:0]         out_packets,
    output logic [$clog2(WAYS+1)-1:0]      out_count,
    output logic [$clog2(DEPTH+1)-1:0]     buf_count
);

    localparam int CW = $clog2(WAYS + 1);
    localparam int BW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    IF_ID_PACKET              mem [DEPTH];
    IF_ID_PACKET [WAYS-1:0]   sorted;
    logic [CW-1:0]            n_in;
    logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
    logic [BW-1:0]            count_q, count_d;
    logic [PW-1:0]            widx [WAYS];
    logic [PW-1:0]            ridx [WAYS];
    logic                     fire;
    int                       n_out;

    function automatic logic [PW-1:0] wrap(input int p, input int n);
        int s;
        s = p + n;
        return PW'((s >= DEPTH) ? s - DEPTH : s);
    endfunction

    id_sort_network #(.WAYS(WAYS)) u_sort (
        .in_packets (in_packets),
        .sorted     (sorted),
        .n_in       (n_in)
    );

    // Pointer/count next state: ready only from registered count, accept clamped to occupancy
    always_comb begin
        in_ready = (DEPTH - int'(count_q)) >= WAYS;
        fire     = in_ready && (n_in != '0);
        n_out    = (int'(out_accept) < int'(count_q)) ? int'(out_accept) : int'(count_q);
        head_d   = wrap(int'(head_q), n_out);
        tail_d   = fire ? wrap(int'(tail_q), int'(n_in)) : tail_q;
        count_d  = BW'(int'(count_q) + (fire ? int'(n_in) : 0) - n_out);
        for (int k = 0; k < WAYS; k++) begin
            widx[k] = wrap(int'(tail_q), k);
            ridx[k] = wrap(int'(head_q), k);
        end
    end

    // Decode view depends only on registered state; lanes past the occupancy show NOP
    always_comb begin
        buf_count = count_q;
        out_count = (int'(count_q) < WAYS) ? CW'(count_q) : CW'(WAYS);
        for (int i = 0; i < WAYS; i++)
            out_packets[i] = (i < int'(count_q)) ? mem[ridx[i]] : NOP_PACKET;
    end

    // Reset beats flush, flush beats enqueue/dequeue
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is never cleared; stale entries are hidden by count
    always_ff @(posedge clock) begin
        if (reset && !flush && fire)
            for (int k = 0; k < WAYS; k++)
                if (k < int'(n_in))
                    mem[widx[k]] <= sorted[k];
    end

endmodule

// File: tb/tb_id_sort_buffer.sv
// tb_id_sort_buffer: directed table-driven check of sort, compaction, backpressure, wrap, flush and reset
module tb_id_sort_buffer;
    import sys_defs::*;

    typedef logic [$bits(IF_ID_PACKET)-1:0] w_t;

    typedef struct {
        logic        fl;
        logic [1:0]  acc;
        logic [2:0]  v;
        logic [31:0] p0, p1, p2;
        int          eb, eoc;
        logic        erdy;
        logic [31:0] e0, e1, e2;
        int          l0, l1, l2;
    } vec_t;

    logic                clock = 1'b0;
    logic                reset, flush;
    IF_ID_PACKET [2:0]   in_packets;
    logic                in_ready;
    logic [1:0]          out_accept;
    IF_ID_PACKET [2:0]   out_packets;
    logic [1:0]          out_count;
    logic [3:0]          buf_count;
    int                  tests = 0;
    int                  fails = 0;
    vec_t                vt [14];

    always #5 clock = ~clock;

    id_sort_buffer #(.WAYS(3), .DEPTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_packets  (in_packets),
        .in_ready    (in_ready),
        .out_accept  (out_accept),
        .out_packets (out_packets),
        .out_count   (out_count),
        .buf_count   (buf_count)
    );

    function automatic IF_ID_PACKET mk(input logic [31:0] pc, input int lane, input logic v);
        IF_ID_PACKET p;
        p.inst  = pc | (32'(lane) << 28);
        p.pc    = pc;
        p.npc   = pc + 32'd4;
        p.valid = v;
        return p;
    endfunction

    function automatic vec_t mv(input logic fl, input logic [1:0] acc, input logic [2:0] v,
                                input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                                input int eb, input int eoc, input logic erdy,
                                input logic [31:0] e0, input int l0, input logic [31:0] e1, input int l1,
                                input logic [31:0] e2, input int l2);
        vec_t t;
        t.fl = fl; t.acc = acc; t.v = v; t.p0 = p0; t.p1 = p1; t.p2 = p2;
        t.eb = eb; t.eoc = eoc; t.erdy = erdy;
        t.e0 = e0; t.l0 = l0; t.e1 = e1; t.l1 = l1; t.e2 = e2; t.l2 = l2;
        return t;
    endfunction

    task automatic chk(input string nm, input w_t got, input w_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic [1:0] acc, input logic [2:0] v,
                         input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2);
        flush         = fl;
        out_accept    = acc;
        in_packets[0] = mk(p0, 0, v[0]);
        in_packets[1] = mk(p1, 1, v[1]);
        in_packets[2] = mk(p2, 2, v[2]);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, " buf_count"}, w_t'(buf_count), w_t'(0));
        chk({tag, " out_count"}, w_t'(out_count), w_t'(0));
        chk({tag, " in_ready"}, w_t'(in_ready), w_t'(1));
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s out%0d", tag, i), w_t'(out_packets[i]), w_t'(NOP_PACKET));
    endtask

    initial begin
        logic [31:0] ep [3];
        int          el [3];
        vt[0]  = mv(0, 0, 3'b111, 32'h108, 32'h100, 32'h104, 3, 3, 1, 32'h100, 1, 32'h104, 2, 32'h108, 0);
        vt[1]  = mv(0, 0, 3'b101, 32'h200, 32'h050, 32'h200, 5, 3, 1, 32'h100, 1, 32'h104, 2, 32'h108, 0);
        vt[2]  = mv(0, 0, 3'b001, 32'h300, 32'h010, 32'h020, 6, 3, 0, 32'h100, 1, 32'h104, 2, 32'h108, 0);
        vt[3]  = mv(0, 0, 3'b111, 32'h400, 32'h404, 32'h408, 6, 3, 0, 32'h100, 1, 32'h104, 2, 32'h108, 0);
        vt[4]  = mv(0, 3, 3'b111, 32'h400, 32'h404, 32'h408, 3, 3, 1, 32'h200, 0, 32'h200, 2, 32'h300, 0);
        vt[5]  = mv(0, 0, 3'b110, 32'h030, 32'h404, 32'h400, 5, 3, 1, 32'h200, 0, 32'h200, 2, 32'h300, 0);
        vt[6]  = mv(0, 3, 3'b000, 32'h0,   32'h0,   32'h0,   2, 2, 1, 32'h400, 2, 32'h404, 1, 32'h0,   0);
        vt[7]  = mv(0, 2, 3'b111, 32'h508, 32'h500, 32'h504, 3, 3, 1, 32'h500, 1, 32'h504, 2, 32'h508, 0);
        vt[8]  = mv(0, 0, 3'b011, 32'h600, 32'h610, 32'h040, 5, 3, 1, 32'h500, 1, 32'h504, 2, 32'h508, 0);
        vt[9]  = mv(1, 3, 3'b111, 32'h700, 32'h704, 32'h708, 0, 0, 1, 32'h0,   0, 32'h0,   0, 32'h0,   0);
        vt[10] = mv(0, 3, 3'b111, 32'h800, 32'h800, 32'h800, 3, 3, 1, 32'h800, 0, 32'h800, 1, 32'h800, 2);
        vt[11] = mv(0, 3, 3'b000, 32'h0,   32'h0,   32'h0,   0, 0, 1, 32'h0,   0, 32'h0,   0, 32'h0,   0);
        vt[12] = mv(0, 3, 3'b100, 32'h0,   32'h0,   32'h900, 1, 1, 1, 32'h900, 2, 32'h0,   0, 32'h0,   0);
        vt[13] = mv(0, 2, 3'b000, 32'h0,   32'h0,   32'h0,   0, 0, 1, 32'h0,   0, 32'h0,   0, 32'h0,   0);

        reset = 1'b0;
        drive(0, 0, 3'b111, 32'h108, 32'h100, 32'h104);
        repeat (2) step();
        chk_empty("reset");

        reset = 1'b1;
        for (int r = 0; r < 14; r++) begin
            drive(vt[r].fl, vt[r].acc, vt[r].v, vt[r].p0, vt[r].p1, vt[r].p2);
            step();
            ep[0] = vt[r].e0; ep[1] = vt[r].e1; ep[2] = vt[r].e2;
            el[0] = vt[r].l0; el[1] = vt[r].l1; el[2] = vt[r].l2;
            chk($sformatf("row%0d buf_count", r), w_t'(buf_count), w_t'(vt[r].eb));
            chk($sformatf("row%0d out_count", r), w_t'(out_count), w_t'(vt[r].eoc));
            chk($sformatf("row%0d in_ready", r), w_t'(in_ready), w_t'(vt[r].erdy));
            for (int i = 0; i < 3; i++)
                chk($sformatf("row%0d out%0d", r, i), w_t'(out_packets[i]),
                    (i < vt[r].eoc) ? w_t'(mk(ep[i], el[i], 1'b1)) : w_t'(NOP_PACKET));
        end

        drive(0, 0, 3'b111, 32'ha08, 32'ha00, 32'ha04);
        #1;
        chk("nocomb out_count", w_t'(out_count), w_t'(0));
        chk("nocomb out0", w_t'(out_packets[0]), w_t'(NOP_PACKET));
        step();
        chk("latency buf_count", w_t'(buf_count), w_t'(3));
        chk("latency out0", w_t'(out_packets[0]), w_t'(mk(32'ha00, 1, 1'b1)));

        reset = 1'b0;
        drive(0, 0, 3'b111, 32'hb00, 32'hb04, 32'hb08);
        step();
        chk_empty("midreset");
        reset = 1'b1;
        drive(0, 0, 3'b000, 32'h0, 32'h0, 32'h0);
        step();
        chk_empty("postreset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
